// File: rtl/demux_seq_ctrl_pkg.sv
// Shared constants and FSM encoding for the autoencoder demux stage.
// Package ae_pkg: word width, slot count, select width and FSM states.
package ae_pkg;

    localparam int DATA_W = 16;
    localparam int N_OUT  = 9;
    localparam int SEL_W  = $clog2(N_OUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } dm_state_t;

endpackage

// File: rtl/demux_seq_ctrl_if.sv
// Stream-in / frame-out handshake bundle for the demux sequencer.
// master drives the stream and consumes the frame; slave is the sequencer.
interface demux_seq_ctrl_if;
    import ae_pkg::*;

    logic                    start;
    logic                    in_valid;
    logic [DATA_W-1:0]       in_data;
    logic                    in_ready;
    logic [SEL_W-1:0]        select;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, select, out_data, out_valid, busy
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, select, out_data, out_valid, busy
    );

endinterface

// File: rtl/demux_slot_bank.sv
// Registered N_OUT x DATA_W slot bank written one slot at a time.
// Slot k is presented on out_data[k*DATA_W +: DATA_W].
module demux_slot_bank
    import ae_pkg::*;
(
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    wr_en,
    input  logic [SEL_W-1:0]        wr_idx,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [N_OUT*DATA_W-1:0] out_data
);

    logic [N_OUT-1:0][DATA_W-1:0] mem;

    // Clear all slots, or store one word at the indexed slot.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            mem <= '0;
        end else if (wr_en && (wr_idx < SEL_W'(N_OUT))) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign out_data = mem;

endmodule

// File: rtl/demux_seq_ctrl.sv
// Sequencer for the 9-way 16-bit demux: serial words in, 9-word frame out.
// Optional frame counter port enabled by defining DEMUX_FRAME_CNT_EN.
module demux_seq_ctrl
    import ae_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    demux_seq_ctrl_if.slave   bus
`ifdef DEMUX_FRAME_CNT_EN
    ,
    output logic [7:0]        frame_cnt
`endif
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT - 1);

    dm_state_t               state;
    logic [SEL_W-1:0]        sel_q;
    logic                    rdy_q;
    logic                    vld_q;
    logic                    busy_q;
    logic                    wr_en;
    logic [N_OUT*DATA_W-1:0] frame;

    assign wr_en = bus.in_valid & rdy_q;

    // Frame FSM with select counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel_q  <= '0;
            rdy_q  <= 1'b0;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= FILL;
                        sel_q  <= '0;
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (bus.in_valid) begin
                        if (sel_q == LAST) begin
                            state <= FULL;
                            rdy_q <= 1'b0;
                            vld_q <= 1'b1;
                        end else begin
                            sel_q <= sel_q + SEL_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        vld_q <= 1'b0;
                        sel_q <= '0;
                        if (bus.start) begin
                            state <= FILL;
                            rdy_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    sel_q  <= '0;
                    rdy_q  <= 1'b0;
                    vld_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    demux_slot_bank u_bank (
        .clk      (clk),
        .clr_n    (rst_n),
        .wr_en    (wr_en),
        .wr_idx   (sel_q),
        .wr_data  (bus.in_data),
        .out_data (frame)
    );

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.busy      = busy_q;
    assign bus.select    = sel_q;
    assign bus.out_data  = frame;

`ifdef DEMUX_FRAME_CNT_EN
    // Count delivered frames; wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= 8'd0;
        end else if (vld_q && bus.out_ready) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_seq_ctrl.sv
// Directed + randomized bench for demux_seq_ctrl against a frame-level model.
// Define DEMUX_FRAME_CNT_EN to also exercise the frame counter.
module tb_demux_seq_ctrl;
    import ae_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    demux_seq_ctrl_if bus ();

`ifdef DEMUX_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    demux_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DEMUX_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rdy_cnt = 0;

    // Frame-level model: words received so far, whether a frame is held.
    bit          m_fill = 0;
    bit          m_full = 0;
    int          m_cnt = 0;
    logic [15:0] ms [N_OUT];
    int          m_fc = 0;

    task automatic chk(input string tag, input logic [143:0] obs,
                       input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [143:0] ef;
        int esel;
        ef = '0;
        for (int k = 0; k < N_OUT; k++) ef[k*16 +: 16] = ms[k];
        esel = m_fill ? m_cnt : (m_full ? N_OUT - 1 : 0);
        chk({tag, "_in_ready"}, 144'(bus.in_ready), 144'(m_fill));
        chk({tag, "_out_valid"}, 144'(bus.out_valid), 144'(m_full));
        chk({tag, "_busy"}, 144'(bus.busy), 144'(m_fill | m_full));
        chk({tag, "_select"}, 144'(bus.select), 144'(esel));
        chk({tag, "_out_data"}, bus.out_data, ef);
`ifdef DEMUX_FRAME_CNT_EN
        chk({tag, "_frame_cnt"}, 144'(frame_cnt), 144'(m_fc));
`endif
    endtask

    // One clock: drive inputs, advance the model, check outputs.
    task automatic step(input string tag, input bit rst, input bit st,
                        input bit iv, input logic [15:0] d, input bit ordy);
        @(negedge clk);
        rst_n         = ~rst;
        bus.start     = st;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(posedge clk);
        if (rst) begin
            m_fill = 0;
            m_full = 0;
            m_cnt  = 0;
            m_fc   = 0;
            for (int k = 0; k < N_OUT; k++) ms[k] = '0;
        end else if (m_full) begin
            if (ordy) begin
                m_fc   = (m_fc + 1) % 256;
                m_full = 0;
                m_fill = st;
                m_cnt  = 0;
            end
        end else if (m_fill) begin
            if (iv) begin
                ms[m_cnt] = d;
                m_cnt++;
                if (m_cnt == N_OUT) begin
                    m_fill = 0;
                    m_full = 1;
                end
            end
        end else if (st) begin
            m_fill = 1;
            m_cnt  = 0;
        end
        #1;
        if (bus.in_ready === 1'b1) rdy_cnt++;
        check_all(tag);
    endtask

    // Send n words; gap: 0 none, 1 alternate, 2 random. seq uses k+1.
    task automatic fill(input string tag, input int n, input int gap,
                        input bit seq, input bit st_pulse);
        for (int k = 0; k < n; k++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(1) == 1))
                step(tag, 0, st_pulse, 0, 16'($urandom), 1'($urandom));
            step(tag, 0, st_pulse & k[0], 1,
                 seq ? 16'(k + 1) : 16'($urandom), 1'($urandom));
        end
    endtask

    logic [143:0] f1;

    initial begin
        bus.start = 0;
        bus.in_valid = 0;
        bus.in_data = '0;
        bus.out_ready = 0;
        for (int k = 0; k < N_OUT; k++) ms[k] = '0;

        step("reset", 1, 0, 0, 16'hFFFF, 0);
        step("reset", 1, 1, 1, 16'hFFFF, 1);

        rdy_cnt = 0;
        step("s1_start", 0, 1, 0, 16'h0, 0);
        fill("s1", N_OUT, 0, 1, 0);
        chk("s1_rdy_cycles", 144'(rdy_cnt), 144'(9));
        for (int k = 0; k < N_OUT; k++)
            chk("s1_slot", 144'(bus.out_data[k*16 +: 16]), 144'(k + 1));
        f1 = bus.out_data;
        step("s1_take", 0, 0, 0, 16'h0, 1);

        step("s2_start", 0, 1, 0, 16'h0, 0);
        fill("s2", N_OUT, 1, 1, 0);
        chk("s2_frame", bus.out_data, f1);

        for (int i = 0; i < 5; i++)
            step("s3_hold", 0, i[0], 0, 16'($urandom), 0);
        chk("s3_frame_held", bus.out_data, f1);
        step("s3_take_start", 0, 1, 0, 16'h0, 1);
        chk("s3_sel0", 144'(bus.select), 144'(0));

        fill("s4", 4, 2, 0, 0);
        step("s4_rst", 1, 0, 1, 16'($urandom), 0);
        chk("s4_data_clr", bus.out_data, 144'(0));
        step("s4_start", 0, 1, 0, 16'h0, 0);
        fill("s4_new", N_OUT, 2, 0, 0);
        step("s4_take", 0, 0, 0, 16'h0, 1);

        step("s5_start", 0, 1, 0, 16'h0, 0);
        fill("s5", N_OUT, 2, 0, 1);
        step("s5_full_start", 0, 1, 0, 16'h0, 0);
        step("s5_take", 0, 0, 0, 16'h0, 1);

        for (int i = 0; i < 6; i++) begin
            step("rnd_start", 0, 1, 0, 16'h0, 1'($urandom));
            fill("rnd", N_OUT, 2, 0, 1'($urandom));
            step("rnd_take", 0, 1'($urandom), 0, 16'h0, 1);
        end

`ifdef DEMUX_FRAME_CNT_EN
        step("s6_rst", 1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 257; i++) begin
            step("s6_start", 0, 1, 0, 16'h0, 0);
            fill("s6", N_OUT, 0, 0, 0);
            step("s6_take", 0, 0, 0, 16'h0, 1);
        end
        chk("s6_wrap", 144'(frame_cnt), 144'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
